// File: rtl/wb_ram_arbiter_if.sv
// Wishbone classic bus bundle shared by the requesting masters and the RAM side of the arbiter.
interface wb_ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
  modport slave (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
  // The shared RAM never signals errors, so its side carries no err.
  modport ram_master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
endinterface

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of one shared RAM slave: round-robin on ties,
// grant held for a whole bus cycle, stalled strobes terminated with err after TIMEOUT cycles.
module wb_ram_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_ram_arbiter_if.slave      m0,
  wb_ram_arbiter_if.slave      m1,
  wb_ram_arbiter_if.ram_master s
);
  // state  | meaning
  // IDLE   | bus released, arbitrating between pending cyc requests
  // GRANT0 | master 0 owns the RAM until it drops cyc or times out
  // GRANT1 | master 1 owns the RAM until it drops cyc or times out
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [7:0]      stall_q, stall_d;

  logic            own1;
  logic            g_cyc, g_stb, g_we;
  logic [AW-1:0]   g_adr;
  logic [DW/8-1:0] g_sel;
  logic [DW-1:0]   g_dat_w;
  logic            timeout_hit;

  assign own1    = (state_q == GRANT1);
  assign g_cyc   = own1 ? m1.cyc   : m0.cyc;
  assign g_stb   = own1 ? m1.stb   : m0.stb;
  assign g_we    = own1 ? m1.we    : m0.we;
  assign g_adr   = own1 ? m1.adr   : m0.adr;
  assign g_sel   = own1 ? m1.sel   : m0.sel;
  assign g_dat_w = own1 ? m1.dat_w : m0.dat_w;

  // The current cycle is the TIMEOUT-th stalled one when the count so far is TIMEOUT-1.
  assign timeout_hit = ({1'b0, stall_q} + 9'd1) == 9'(TIMEOUT);

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;
    s.cyc        = 1'b0;
    s.stb        = 1'b0;
    s.we         = 1'b0;
    s.adr        = '0;
    s.sel        = '0;
    s.dat_w      = '0;
    m0.ack       = 1'b0;
    m0.err       = 1'b0;
    m1.ack       = 1'b0;
    m1.err       = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (m0.cyc && (!m1.cyc || last_grant_q)) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
        end else if (m1.cyc) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        s.cyc   = g_cyc;
        s.stb   = g_stb;
        s.we    = g_we;
        s.adr   = g_adr;
        s.sel   = g_sel;
        s.dat_w = g_dat_w;
        m0.ack  = !own1 && s.ack;
        m1.ack  = own1 && s.ack;
        if (!g_stb || s.ack) begin
          stall_d = '0;
        end else if (timeout_hit) begin
          s.cyc   = 1'b0;
          s.stb   = 1'b0;
          m0.err  = !own1;
          m1.err  = own1;
          stall_d = '0;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + 8'd1;
        end
        if (!g_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
    end
  end
endmodule
